z80_bus_cycle_gen: RTL and testbench
====================================

Name: z80_bus_cycle_gen

Overview:
Parametrised Z80-style external bus cycle sequencer. A host (CPU core or DMA engine) issues one bus transaction per request. The block runs the T-state machine and drives mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n, including programmable forced wait states, selectable write-strobe timing, refresh addressing and bus-request arbitration. It replaces ad-hoc strobe decoding around the CPU core with a single reusable bus front end.

Parameters:
ADDR_W, 16, address bus width (>= RFSH_W+1)
DATA_W, 8, data bus width
MEM_WAIT, 0, forced wait states on memory read/write cycles (0..7); none on M1 fetch
IO_WAIT, 1, forced wait states on IO read/write and interrupt-acknowledge cycles (0..7)
T2_WRITE, 0, 0: wr_n low in T3 only; 1: wr_n low from T2 through T3
RFSH_W, 7, width of the refresh counter placed on A[RFSH_W-1:0]

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req  in  1  host transaction request, level, sampled at cycle boundary
cyc_type  in  3  0 M1 fetch, 1 mem rd, 2 mem wr, 3 io rd, 4 io wr, 5 int ack; 6,7 treated as mem rd
addr_in  in  ADDR_W  transaction address
wdata  in  DATA_W  write data
ack  out  1  one-cycle pulse: transaction complete, rdata valid
rdata  out  DATA_W  captured read/fetch/vector data, held until next capture
busy  out  1  high from T1 through the last T-state
wait_n  in  1  external wait, active low
busrq_n  in  1  external bus request, active low
busak_n  out  1  bus acknowledge, active low
bus_oe  out  1  1 = block drives A/data_out/strobes; 0 while bus granted
A  out  ADDR_W  address bus
data_out  out  DATA_W  write data bus
data_in  in  DATA_W  read data bus
m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  out  1 each  Z80 bus strobes, active low

Behaviour:
- Reset (async): state IDLE; all strobes 1, busak_n=1, bus_oe=1, ack=0, busy=0, A=0, data_out=0, rdata=0, refresh counter=0, wait counter=0. Reset asserted mid-cycle aborts the cycle with no ack; strobes go high immediately.
- States: IDLE, T1, T2, TW, T3, T4, BUSGNT. One T-state per clock. Outputs are registered and reflect the current state.
- IDLE: if busrq_n=0, go to BUSGNT (busrq_n has priority over req). Else if req=1, latch cyc_type/addr_in/wdata and go to T1. A holds the last address.
- T1: A=latched address; data_out=wdata for writes. m1_n=0 for fetch and int ack. All other strobes high.
- T2: fetch/mem rd: mreq_n=rd_n=0. io rd: iorq_n=rd_n=0. Writes: mreq_n (or iorq_n)=0, wr_n=0 only if T2_WRITE=1. Int ack: m1_n=0, iorq_n=0. On entering T2 the wait counter loads: MEM_WAIT for mem rd/wr, IO_WAIT for io/int ack, 0 for fetch.
- Leaving T2 or TW: go to TW if counter!=0 or wait_n=0 (sampled that edge); the counter decrements per TW, saturating at 0. Otherwise go to T3. TW holds the T2 strobe values; wr_n=0 in TW if T2_WRITE=1.
- Fetch/int ack: rdata captures data_in on the edge leaving T2/TW to T3. T3 and T4 are refresh: m1_n=1, rd_n=1, iorq_n=1, rfsh_n=0, mreq_n=0, A={zeros, refresh counter}. The refresh counter increments (mod 2^RFSH_W) on the edge leaving T4. The cycle ends after T4.
- Rd/wr cycles: T3 holds the strobes low (wr_n=0 in T3 for all writes). Reads capture data_in on the edge leaving T3. The cycle ends after T3.
- Cycle end: ack=1 for exactly the next clock and busy drops. If busrq_n=0, go to BUSGNT. Else if req=1, latch the new request and go directly to T1 (back-to-back, no IDLE). Else go to IDLE.
- BUSGNT: busak_n=0, bus_oe=0, all strobes 1. Return to IDLE on the edge after busrq_n is sampled 1. busrq_n is never honoured mid-cycle.
- wait_n is ignored in all states except T2/TW.

Test Plan:
- Mem rd, MEM_WAIT=0, addr 0x1234, data_in=0x5A, wait_n=1 -> T1,T2,T3; mreq_n/rd_n low 2 clocks; ack next clock; rdata=0x5A.
- M1 fetch addr 0x0100, data_in=0xC3 -> m1_n low T1–T2; rfsh_n/mreq_n low T3–T4 with A=0x0000; then refresh count=1 and rdata=0xC3; 128 fetches wrap the counter to 0.
- IO wr addr 0x00FE, wdata 0x77, IO_WAIT=1, wait_n held 0 for 2 clocks in T2 -> 3 TW states total; iorq_n low from T2; wr_n low in T3 only (T2_WRITE=0); T2_WRITE=1 -> wr_n low from T2.
- Back-to-back: req held high over mem wr then mem rd -> T1 of the second follows T3 of the first with no IDLE; two ack pulses.
- busrq_n=0 asserted during T2 of a mem rd -> cycle completes with ack, then busak_n=0 and bus_oe=0; busrq_n=1 -> IDLE next edge.
- reset_n=0 in TW -> strobes=1 and no ack; after release, state is IDLE.

Source files
------------

// File: rtl/z80_bus_cycle_gen_if.sv
// Bundles the host request/response and Z80 external bus signals of z80_bus_cycle_gen.
//   Host side : req, cyc_type, addr_in, wdata -> ack, rdata, busy
//   Bus side  : wait_n, busrq_n, data_in      -> busak_n, bus_oe, A, data_out, strobes
// Modports:
//   slave  - the bus cycle generator (serves host requests, drives the Z80 bus)
//   master - the host plus external bus environment
interface z80_bus_cycle_gen_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              req;
  logic [2:0]        cyc_type;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              wait_n;
  logic              busrq_n;
  logic              busak_n;
  logic              bus_oe;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic              m1_n;
  logic              mreq_n;
  logic              iorq_n;
  logic              rd_n;
  logic              wr_n;
  logic              rfsh_n;

  modport slave (
    input  req, cyc_type, addr_in, wdata, wait_n, busrq_n, data_in,
    output ack, rdata, busy, busak_n, bus_oe, A, data_out,
           m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n
  );

  modport master (
    output req, cyc_type, addr_in, wdata, wait_n, busrq_n, data_in,
    input  ack, rdata, busy, busak_n, bus_oe, A, data_out,
           m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n
  );
endinterface

// File: rtl/z80_bus_cycle_gen.sv
// Z80-style external bus cycle sequencer. Runs one T-state per clock for each host
// transaction (M1 fetch, mem rd/wr, io rd/wr, int ack), inserts forced and external
// wait states, generates refresh cycles after M1/int ack and arbitrates busrq_n.
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - z80_bus_cycle_gen_if.slave: host request/response and Z80 bus pins
// All outputs are registered; they are computed from the next state so that the
// pins line up with the state the machine is in during each clock.
module z80_bus_cycle_gen #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1,
  parameter int unsigned T2_WRITE = 0,
  parameter int unsigned RFSH_W   = 7
) (
  input logic               clk,
  input logic               reset_n,
  z80_bus_cycle_gen_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StT1,
    StT2,
    StTw,
    StT3,
    StT4,
    StBusGnt
  } state_e;

  localparam logic [2:0] CycM1    = 3'd0;
  localparam logic [2:0] CycMemRd = 3'd1;
  localparam logic [2:0] CycMemWr = 3'd2;
  localparam logic [2:0] CycIoRd  = 3'd3;
  localparam logic [2:0] CycIoWr  = 3'd4;
  localparam logic [2:0] CycIntAck = 3'd5;

  localparam logic [2:0] MemWaitLd = 3'(MEM_WAIT);
  localparam logic [2:0] IoWaitLd  = 3'(IO_WAIT);

  // Reserved encodings behave as memory reads.
  function automatic logic [2:0] norm_type(logic [2:0] t);
    return (t > CycIntAck) ? CycMemRd : t;
  endfunction

  function automatic logic fetch_like(logic [2:0] t);
    return (t == CycM1) || (t == CycIntAck);
  endfunction

  function automatic logic is_write(logic [2:0] t);
    return (t == CycMemWr) || (t == CycIoWr);
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          typ_q, typ_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          wcnt_q, wcnt_d;
  logic [RFSH_W-1:0]   rfsh_q, rfsh_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                cyc_end;
  logic                load;

  logic                m1_q, mreq_q, iorq_q, rd_q, wr_q, rfsh_n_q;
  logic                m1_d, mreq_d, iorq_d, rd_d, wr_d, rfsh_n_d;
  logic                busak_q, busak_d;
  logic                oe_q, oe_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                refresh;
  logic                wr_low;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    typ_d   = typ_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    rfsh_d  = rfsh_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    cyc_end = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!bus.busrq_n) begin
          state_d = StBusGnt;
        end else if (bus.req) begin
          state_d = StT1;
          load    = 1'b1;
        end
      end
      StT1: begin
        state_d = StT2;
        unique case (typ_q)
          CycM1:              wcnt_d = 3'd0;
          CycMemRd, CycMemWr: wcnt_d = MemWaitLd;
          default:            wcnt_d = IoWaitLd;
        endcase
      end
      StT2, StTw: begin
        if ((wcnt_q != 3'd0) || !bus.wait_n) begin
          state_d = StTw;
          wcnt_d  = (wcnt_q == 3'd0) ? 3'd0 : wcnt_q - 3'd1;
        end else begin
          state_d = StT3;
          // Fetch/vector data is taken before the refresh half of the cycle.
          if (fetch_like(typ_q)) begin
            rdata_d = bus.data_in;
          end
        end
      end
      StT3: begin
        if (fetch_like(typ_q)) begin
          state_d = StT4;
        end else begin
          if ((typ_q == CycMemRd) || (typ_q == CycIoRd)) begin
            rdata_d = bus.data_in;
          end
          cyc_end = 1'b1;
        end
      end
      StT4: begin
        rfsh_d  = rfsh_q + 1'b1;
        cyc_end = 1'b1;
      end
      StBusGnt: begin
        if (bus.busrq_n) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // busrq_n is only honoured here and in idle, never inside a cycle.
    if (cyc_end) begin
      ack_d = 1'b1;
      if (!bus.busrq_n) begin
        state_d = StBusGnt;
      end else if (bus.req) begin
        state_d = StT1;
        load    = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end

    if (load) begin
      typ_d   = norm_type(bus.cyc_type);
      addr_d  = bus.addr_in;
      wdata_d = bus.wdata;
    end
  end

  // Output decode for the state being entered.
  always_comb begin
    m1_d     = 1'b1;
    mreq_d   = 1'b1;
    iorq_d   = 1'b1;
    rd_d     = 1'b1;
    wr_d     = 1'b1;
    rfsh_n_d = 1'b1;
    busak_d  = 1'b1;
    oe_d     = 1'b1;
    busy_d   = 1'b0;
    a_d      = a_q;
    dout_d   = dout_q;
    refresh  = ((state_d == StT3) && fetch_like(typ_d)) || (state_d == StT4);
    wr_low   = (state_d == StT3) || (T2_WRITE != 0);

    unique case (state_d)
      StT1: begin
        busy_d = 1'b1;
        a_d    = addr_d;
        if (is_write(typ_d)) begin
          dout_d = wdata_d;
        end
        if (fetch_like(typ_d)) begin
          m1_d = 1'b0;
        end
      end
      StT2, StTw, StT3, StT4: begin
        busy_d = 1'b1;
        if (refresh) begin
          mreq_d   = 1'b0;
          rfsh_n_d = 1'b0;
          a_d      = ADDR_W'(rfsh_d);
        end else begin
          a_d = addr_d;
          unique case (typ_d)
            CycM1: begin
              m1_d   = 1'b0;
              mreq_d = 1'b0;
              rd_d   = 1'b0;
            end
            CycMemWr: begin
              mreq_d = 1'b0;
              wr_d   = !wr_low;
            end
            CycIoRd: begin
              iorq_d = 1'b0;
              rd_d   = 1'b0;
            end
            CycIoWr: begin
              iorq_d = 1'b0;
              wr_d   = !wr_low;
            end
            CycIntAck: begin
              m1_d   = 1'b0;
              iorq_d = 1'b0;
            end
            default: begin
              mreq_d = 1'b0;
              rd_d   = 1'b0;
            end
          endcase
        end
      end
      StBusGnt: begin
        busak_d = 1'b0;
        oe_d    = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      typ_q    <= CycM1;
      addr_q   <= '0;
      wdata_q  <= '0;
      wcnt_q   <= 3'd0;
      rfsh_q   <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      m1_q     <= 1'b1;
      mreq_q   <= 1'b1;
      iorq_q   <= 1'b1;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      rfsh_n_q <= 1'b1;
      busak_q  <= 1'b1;
      oe_q     <= 1'b1;
      busy_q   <= 1'b0;
      a_q      <= '0;
      dout_q   <= '0;
    end else begin
      typ_q    <= typ_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wcnt_q   <= wcnt_d;
      rfsh_q   <= rfsh_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      m1_q     <= m1_d;
      mreq_q   <= mreq_d;
      iorq_q   <= iorq_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rfsh_n_q <= rfsh_n_d;
      busak_q  <= busak_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.busak_n  = busak_q;
  assign bus.bus_oe   = oe_q;
  assign bus.A        = a_q;
  assign bus.data_out = dout_q;
  assign bus.m1_n     = m1_q;
  assign bus.mreq_n   = mreq_q;
  assign bus.iorq_n   = iorq_q;
  assign bus.rd_n     = rd_q;
  assign bus.wr_n     = wr_q;
  assign bus.rfsh_n   = rfsh_n_q;

endmodule

// File: tb/tb_z80_bus_cycle_gen.sv
// Directed bench for z80_bus_cycle_gen. Inputs change and outputs are sampled on the
// falling clock edge. A second instance with T2_WRITE=1 sees the same stimulus.
// Strobe vectors are {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n}.
module tb_z80_bus_cycle_gen;

  logic clk;
  logic reset_n;
  int   n_total;
  int   n_bad;

  z80_bus_cycle_gen_if #(.ADDR_W(16), .DATA_W(8)) bif ();
  z80_bus_cycle_gen_if #(.ADDR_W(16), .DATA_W(8)) bif2 ();

  z80_bus_cycle_gen #(
    .ADDR_W  (16),
    .DATA_W  (8),
    .MEM_WAIT(0),
    .IO_WAIT (1),
    .T2_WRITE(0),
    .RFSH_W  (7)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bif)
  );

  z80_bus_cycle_gen #(
    .ADDR_W  (16),
    .DATA_W  (8),
    .MEM_WAIT(0),
    .IO_WAIT (1),
    .T2_WRITE(1),
    .RFSH_W  (7)
  ) u_dut_t2w (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bif2)
  );

  assign bif2.req      = bif.req;
  assign bif2.cyc_type = bif.cyc_type;
  assign bif2.addr_in  = bif.addr_in;
  assign bif2.wdata    = bif.wdata;
  assign bif2.wait_n   = bif.wait_n;
  assign bif2.busrq_n  = bif.busrq_n;
  assign bif2.data_in  = bif.data_in;

  logic [5:0] s1, s2;
  assign s1 = {bif.m1_n, bif.mreq_n, bif.iorq_n, bif.rd_n, bif.wr_n, bif.rfsh_n};
  assign s2 = {bif2.m1_n, bif2.mreq_n, bif2.iorq_n, bif2.rd_n, bif2.wr_n, bif2.rfsh_n};

  localparam logic [5:0] SIdle  = 6'b111111;
  localparam logic [5:0] SM1T1  = 6'b011111;
  localparam logic [5:0] SFetch = 6'b001011;
  localparam logic [5:0] SRfsh  = 6'b101110;
  localparam logic [5:0] SMemRd = 6'b101011;
  localparam logic [5:0] SMemWr = 6'b101111;
  localparam logic [5:0] SMemWl = 6'b101101;
  localparam logic [5:0] SIoRd  = 6'b110011;
  localparam logic [5:0] SIoWr  = 6'b110111;
  localparam logic [5:0] SIoWl  = 6'b110101;
  localparam logic [5:0] SInta  = 6'b010111;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  // Presents a request; returns at the falling edge inside T1 with req still high.
  task automatic issue(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d);
    bif.req      = 1'b1;
    bif.cyc_type = t;
    bif.addr_in  = a;
    bif.wdata    = d;
    nx();
  endtask

  task automatic wait_ack(input string tag);
    for (int i = 0; i < 20 && !bif.ack; i++) nx();
    check(tag, bif.ack, 1'b1);
  endtask

  initial begin
    n_total      = 0;
    n_bad        = 0;
    reset_n      = 1'b0;
    bif.req      = 1'b0;
    bif.cyc_type = 3'd0;
    bif.addr_in  = '0;
    bif.wdata    = '0;
    bif.wait_n   = 1'b1;
    bif.busrq_n  = 1'b1;
    bif.data_in  = '0;

    nx();
    check("rst_strb", s1, SIdle);
    check("rst_A", bif.A, 16'h0000);
    check("rst_busy", bif.busy, 1'b0);
    check("rst_ack", bif.ack, 1'b0);
    check("rst_busak", {bif.busak_n, bif.bus_oe}, 2'b11);
    check("rst_rdata", bif.rdata, 8'h00);
    reset_n = 1'b1;
    nx();

    // Memory read, no waits.
    bif.data_in = 8'h5A;
    issue(3'd1, 16'h1234, 8'h00);
    bif.req = 1'b0;
    check("mrd_t1_A", bif.A, 16'h1234);
    check("mrd_t1_strb", s1, SIdle);
    check("mrd_t1_busy", bif.busy, 1'b1);
    nx();
    check("mrd_t2_strb", s1, SMemRd);
    nx();
    check("mrd_t3_strb", s1, SMemRd);
    check("mrd_t3_ack", bif.ack, 1'b0);
    nx();
    check("mrd_end_ack", bif.ack, 1'b1);
    check("mrd_end_busy", bif.busy, 1'b0);
    check("mrd_end_strb", s1, SIdle);
    check("mrd_rdata", bif.rdata, 8'h5A);
    check("mrd_A_hold", bif.A, 16'h1234);
    nx();
    check("mrd_ack_pulse", bif.ack, 1'b0);

    // M1 fetch with refresh.
    bif.data_in = 8'hC3;
    issue(3'd0, 16'h0100, 8'h00);
    bif.req = 1'b0;
    check("m1_t1_strb", s1, SM1T1);
    check("m1_t1_A", bif.A, 16'h0100);
    nx();
    check("m1_t2_strb", s1, SFetch);
    nx();
    check("m1_t3_strb", s1, SRfsh);
    check("m1_t3_A", bif.A, 16'h0000);
    check("m1_rdata", bif.rdata, 8'hC3);
    nx();
    check("m1_t4_strb", s1, SRfsh);
    check("m1_t4_A", bif.A, 16'h0000);
    nx();
    check("m1_ack", bif.ack, 1'b1);
    check("m1_end_strb", s1, SIdle);

    bif.data_in = 8'h00;
    issue(3'd0, 16'h0200, 8'h00);
    bif.req = 1'b0;
    nx();
    nx();
    check("m1b_rfsh_A", bif.A, 16'h0001);
    wait_ack("m1b_ack");

    // 126 more fetches bring the total to 128: counter wraps to 0.
    for (int k = 0; k < 126; k++) begin
      issue(3'd0, 16'h0300, 8'h00);
      bif.req = 1'b0;
      wait_ack("m1_loop_ack");
    end
    issue(3'd0, 16'h0400, 8'h00);
    bif.req = 1'b0;
    nx();
    nx();
    check("m1_wrap_A", bif.A, 16'h0000);
    wait_ack("m1_wrap_ack");

    // Interrupt acknowledge with one forced wait state.
    bif.data_in = 8'hFF;
    issue(3'd5, 16'h0038, 8'h00);
    bif.req = 1'b0;
    check("inta_t1_strb", s1, SM1T1);
    nx();
    check("inta_t2_strb", s1, SInta);
    nx();
    check("inta_tw_strb", s1, SInta);
    nx();
    check("inta_t3_strb", s1, SRfsh);
    check("inta_rdata", bif.rdata, 8'hFF);
    wait_ack("inta_ack");

    // IO write: one forced wait plus wait_n low for two clocks gives three TW.
    issue(3'd4, 16'h00FE, 8'h77);
    bif.req = 1'b0;
    check("iowr_t1_strb", s1, SIdle);
    check("iowr_t1_A", bif.A, 16'h00FE);
    check("iowr_dout", bif.data_out, 8'h77);
    nx();
    check("iowr_t2_strb", s1, SIoWr);
    check("iowr_t2_strb_t2w", s2, SIoWl);
    nx();
    check("iowr_tw1_strb", s1, SIoWr);
    check("iowr_tw1_strb_t2w", s2, SIoWl);
    bif.wait_n = 1'b0;
    nx();
    check("iowr_tw2_strb", s1, SIoWr);
    nx();
    check("iowr_tw3_strb", s1, SIoWr);
    check("iowr_tw3_busy", bif.busy, 1'b1);
    bif.wait_n = 1'b1;
    nx();
    check("iowr_t3_strb", s1, SIoWl);
    check("iowr_t3_strb_t2w", s2, SIoWl);
    check("iowr_t3_ack", bif.ack, 1'b0);
    nx();
    check("iowr_ack", bif.ack, 1'b1);

    // Back-to-back mem write then mem read with req held high.
    bif.data_in = 8'h3C;
    issue(3'd2, 16'h2000, 8'hAA);
    check("b2b_t1_A", bif.A, 16'h2000);
    check("b2b_dout", bif.data_out, 8'hAA);
    bif.cyc_type = 3'd1;
    bif.addr_in  = 16'h2001;
    nx();
    check("b2b_wr_t2_strb", s1, SMemWr);
    nx();
    check("b2b_wr_t3_strb", s1, SMemWl);
    nx();
    check("b2b_rd_t1_A", bif.A, 16'h2001);
    check("b2b_ack1", bif.ack, 1'b1);
    check("b2b_rd_t1_busy", bif.busy, 1'b1);
    check("b2b_rd_t1_strb", s1, SIdle);
    bif.req = 1'b0;
    nx();
    check("b2b_rd_t2_strb", s1, SMemRd);
    check("b2b_ack_gap", bif.ack, 1'b0);
    nx();
    nx();
    check("b2b_ack2", bif.ack, 1'b1);
    check("b2b_rdata", bif.rdata, 8'h3C);
    check("b2b_busy_end", bif.busy, 1'b0);

    // Bus request during T2 of a read (reserved type 7 acts as mem rd).
    bif.data_in = 8'h99;
    issue(3'd7, 16'h4444, 8'h00);
    bif.req = 1'b0;
    nx();
    check("brq_t2_strb", s1, SMemRd);
    bif.busrq_n = 1'b0;
    nx();
    check("brq_t3_busak", bif.busak_n, 1'b1);
    check("brq_t3_strb", s1, SMemRd);
    nx();
    check("brq_ack", bif.ack, 1'b1);
    check("brq_gnt", {bif.busak_n, bif.bus_oe}, 2'b00);
    check("brq_gnt_strb", s1, SIdle);
    check("brq_rdata", bif.rdata, 8'h99);
    nx();
    check("brq_ack_pulse", bif.ack, 1'b0);
    check("brq_gnt_hold", bif.busak_n, 1'b0);
    bif.busrq_n = 1'b1;
    nx();
    check("brq_release", {bif.busak_n, bif.bus_oe}, 2'b11);
    bif.busrq_n  = 1'b0;
    bif.req      = 1'b1;
    bif.cyc_type = 3'd1;
    nx();
    check("brq_prio_busak", bif.busak_n, 1'b0);
    check("brq_prio_busy", bif.busy, 1'b0);
    bif.busrq_n = 1'b1;
    bif.req     = 1'b0;
    nx();
    check("brq_prio_rel", bif.busak_n, 1'b1);
    check("brq_prio_idle", bif.busy, 1'b0);

    // Reset asserted during a wait state of an IO read.
    issue(3'd3, 16'h0033, 8'h00);
    bif.req = 1'b0;
    nx();
    check("iord_t2_strb", s1, SIoRd);
    nx();
    check("iord_tw_strb", s1, SIoRd);
    reset_n = 1'b0;
    #1;
    check("rst_mid_strb", s1, SIdle);
    check("rst_mid_busy", bif.busy, 1'b0);
    check("rst_mid_A", bif.A, 16'h0000);
    check("rst_mid_rdata", bif.rdata, 8'h00);
    nx();
    check("rst_mid_ack", bif.ack, 1'b0);
    reset_n = 1'b1;
    nx();
    check("post_rst_ack", bif.ack, 1'b0);
    check("post_rst_strb", s1, SIdle);
    issue(3'd1, 16'h5555, 8'h00);
    bif.req = 1'b0;
    check("post_rst_t1_A", bif.A, 16'h5555);
    check("post_rst_t1_busy", bif.busy, 1'b1);
    wait_ack("post_rst_ack2");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
